// File: rtl/tm_pack.sv
// Packs 3-bit flag triples into 8-bit test-mode words: two triples per word,
// or one triple alone after an idle timeout or an explicit flush.
module tm_pack #(
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] q,
    input  logic       q_valid,
    output logic       q_ready,
    input  logic       flush,
    output logic [7:0] tm,
    output logic       tm_valid,
    input  logic       tm_ready
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_e;

    localparam logic [7:0] FLUSH_LIMIT = 8'(FLUSH_CYCLES);
    localparam logic [1:0] CNT_ONE     = 2'b01;
    localparam logic [1:0] CNT_TWO     = 2'b10;

    state_e     state_q;
    logic [7:0] idle_cnt_q;
    logic [2:0] held_q;
    logic [7:0] tm_q;
    logic       tm_valid_q;

    logic out_free;
    logic accept;
    logic timed_out;

    assign out_free  = !tm_valid_q || tm_ready;
    // Held low during reset so no transfer can be counted against a block that is clearing.
    assign q_ready   = rst && ((state_q == S_EMPTY) || out_free);
    assign accept    = q_valid && q_ready;
    assign timed_out = (idle_cnt_q == FLUSH_LIMIT) || flush;

    assign tm       = tm_q;
    assign tm_valid = tm_valid_q;

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            idle_cnt_q <= '0;
            held_q     <= '0;
            tm_q       <= '0;
            tm_valid_q <= 1'b0;
        end else begin
            if (tm_valid_q && tm_ready) begin
                tm_valid_q <= 1'b0;
            end

            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        held_q     <= q;
                        idle_cnt_q <= '0;
                        state_q    <= S_HALF;
                    end
                end

                S_HALF: begin
                    if (accept) begin
                        // A second triple always wins over a coincident timeout or flush.
                        tm_q       <= {CNT_TWO, held_q, q};
                        tm_valid_q <= 1'b1;
                        state_q    <= S_EMPTY;
                    end else if (out_free && timed_out) begin
                        tm_q       <= {CNT_ONE, held_q, 3'b000};
                        tm_valid_q <= 1'b1;
                        state_q    <= S_EMPTY;
                    end else if (flush) begin
                        // Blocked flush is remembered by parking the counter at its limit.
                        idle_cnt_q <= FLUSH_LIMIT;
                    end else if (idle_cnt_q != FLUSH_LIMIT) begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end
                end

                default: state_q <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_tm_pack.sv
// Directed bench for tm_pack: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares on every output transfer.
module tb_tm_pack;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] q;
    logic       q_valid;
    logic       q_ready;
    logic       flush;
    logic [7:0] tm;
    logic       tm_valid;
    logic       tm_ready;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    tm_pack #(.FLUSH_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .q        (q),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .flush    (flush),
        .tm       (tm),
        .tm_valid (tm_valid),
        .tm_ready (tm_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] v);
        q_valid = 1'b1;
        q       = v;
        tick();
        q_valid = 1'b0;
    endtask

    // Scoreboard monitor: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && tm_valid && tm_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got 0x%02h, expected no word", tm);
            end else begin
                check("tm_word", tm, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        q        = 3'b000;
        q_valid  = 1'b0;
        flush    = 1'b0;
        tm_ready = 1'b1;

        // Reset state
        #12;
        check("rst_tm_valid", {7'b0, tm_valid}, 8'h00);
        check("rst_tm", tm, 8'h00);
        check("rst_q_ready", {7'b0, q_ready}, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_q_ready", {7'b0, q_ready}, 8'h01);
        check("post_rst_tm_valid", {7'b0, tm_valid}, 8'h00);

        // Pair: 101 then 011 -> 0xAB, valid for exactly one cycle
        exp_q.push_back(8'hAB);
        accept(3'b101);
        accept(3'b011);
        check("pair_valid", {7'b0, tm_valid}, 8'h01);
        check("pair_tm", tm, 8'hAB);
        tick();
        check("pair_valid_drop", {7'b0, tm_valid}, 8'h00);

        // Timeout: 110 alone -> 0x70 appears on the fifth cycle after the accept
        exp_q.push_back(8'h70);
        accept(3'b110);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("timeout_quiet_%0d", i), {7'b0, tm_valid}, 8'h00);
        end
        tick();
        check("timeout_valid", {7'b0, tm_valid}, 8'h01);
        check("timeout_tm", tm, 8'h70);
        tick();

        // Flush: 001 then flush -> 0x48 next cycle
        exp_q.push_back(8'h48);
        accept(3'b001);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", {7'b0, tm_valid}, 8'h01);
        check("flush_tm", tm, 8'h48);
        tick();

        // Flush while empty produces nothing
        flush = 1'b1;
        repeat (6) tick();
        flush = 1'b0;
        check("flush_empty_quiet", {7'b0, tm_valid}, 8'h00);

        // Backpressure: pending 0x94 plus held 111 blocks input until consumer takes the word
        tm_ready = 1'b0;
        exp_q.push_back(8'h94);
        exp_q.push_back(8'hB8);
        accept(3'b010);
        accept(3'b100);
        accept(3'b111);
        q_valid = 1'b1;
        q       = 3'b000;
        #1;
        check("bp_q_ready_low", {7'b0, q_ready}, 8'h00);
        repeat (6) tick();
        check("bp_tm_stable", tm, 8'h94);
        check("bp_valid_held", {7'b0, tm_valid}, 8'h01);
        check("bp_q_ready_still_low", {7'b0, q_ready}, 8'h00);
        tm_ready = 1'b1;
        #1;
        check("bp_q_ready_free", {7'b0, q_ready}, 8'h01);
        tick();
        q_valid = 1'b0;
        check("bp_next_tm", tm, 8'hB8);
        check("bp_next_valid", {7'b0, tm_valid}, 8'h01);
        tick();

        // Tie: second accept lands on the timeout cycle -> only the pair word
        exp_q.push_back(8'h9D);
        accept(3'b011);
        repeat (4) tick();
        check("tie_quiet", {7'b0, tm_valid}, 8'h00);
        accept(3'b101);
        check("tie_tm", tm, 8'h9D);
        tick();
        check("tie_single_absent", {7'b0, tm_valid}, 8'h00);

        // Reset mid-operation discards pending word and held triple
        tm_ready = 1'b0;
        accept(3'b001);
        accept(3'b010);
        accept(3'b110);
        check("pre_rst_valid", {7'b0, tm_valid}, 8'h01);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {7'b0, tm_valid}, 8'h00);
        check("mid_rst_q_ready", {7'b0, q_ready}, 8'h00);
        exp_q.delete();
        tick();
        rst      = 1'b1;
        tm_ready = 1'b1;
        tick();
        check("rel_q_ready", {7'b0, q_ready}, 8'h01);
        check("rel_tm_valid", {7'b0, tm_valid}, 8'h00);
        exp_q.push_back(8'hB9);
        accept(3'b111);
        accept(3'b001);
        check("rel_pair_tm", tm, 8'hB9);
        repeat (8) tick();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL words_outstanding: got %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tm_pack.md
TM_PACK -- requirements
Module: tm_pack

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 4, legal range 1..255: number of idle cycles a lone held triple waits before being emitted alone.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port q, input, 3 bits, tTest: flag triple {a,b,c}, with a at bit 2 and c at bit 0.
REQ-005 SHALL have port q_valid, input, 1 bit: q holds a triple to be accepted.
REQ-006 SHALL have port q_ready, output, 1 bit: the block can accept q this cycle.
REQ-007 SHALL have port flush, input, 1 bit: request to emit a lone held triple immediately.
REQ-008 SHALL have port tm, output, 8 bits: the packed test-mode word.
REQ-009 SHALL have port tm_valid, output, 1 bit: tm holds a word for the consumer.
REQ-010 SHALL have port tm_ready, input, 1 bit: the consumer takes tm this cycle.

Function
REQ-011 SHALL use this tm format: tm[7:6] = triple count (2'b01 = one, 2'b10 = two), tm[5:3] = first triple, tm[2:0] = second triple; tm[2:0] = 3'b000 when the count is one.
REQ-012 SHALL never emit a count of 2'b00 or 2'b11.
REQ-013 SHALL count an input transfer only when q_valid && q_ready, and an output transfer only when tm_valid && tm_ready.
REQ-014 SHALL define out_free = !tm_valid || tm_ready, meaning the output register can be loaded this cycle.
REQ-015 SHALL run a two-state FSM: EMPTY (no triple held) and HALF (one triple held, plus an idle counter).
REQ-016 SHALL drive q_ready = 1 in EMPTY, and q_ready = out_free in HALF; q_ready SHALL be 0 while rst is low.
REQ-017 SHALL, on accept in EMPTY, store q as the held triple, clear the idle counter and go to HALF.
REQ-018 SHALL, on accept in HALF, load tm = {2'b10, held, q}, set tm_valid, and go to EMPTY; latency from second accept to tm_valid is 1 cycle.
REQ-019 SHALL, in HALF with no accept, increment the idle counter each cycle, saturating at FLUSH_CYCLES.
REQ-020 SHALL, in HALF with no accept, out_free = 1, and (counter == FLUSH_CYCLES or flush = 1), load tm = {2'b01, held, 3'b000}, set tm_valid, and go to EMPTY.
REQ-021 SHALL, when an accept and a timeout or flush occur in the same cycle in HALF, form the pair word and ignore the timeout or flush.
REQ-022 SHALL, in HALF with a timeout or flush pending but out_free = 0, stay in HALF with the counter held at saturation and emit once out_free = 1.
REQ-023 SHALL ignore flush in EMPTY.
REQ-024 SHALL hold tm and tm_valid stable while tm_valid && !tm_ready.
REQ-025 SHALL clear tm_valid after an output transfer unless a new word loads in the same cycle, giving back-to-back throughput of one word per cycle.
REQ-026 SHALL keep every triple: no drop, no duplicate, and arrival order preserved across words.

Reset
REQ-027 SHALL, while rst = 0, force state = EMPTY, idle counter = 0, held triple = 3'b000, tm = 8'h00, tm_valid = 0 and q_ready = 0, asynchronously.
REQ-028 SHALL discard any held triple and any pending tm word when reset asserts mid-operation; after release the first accept SHALL start a new word.
REQ-029 SHALL not exhibit tm_valid = 1 or q_ready = 0 caused by pre-reset state on the first rising edge after rst rises.

Verification
REQ-030 Pair: with tm_ready = 1, accept q = 3'b101, then q = 3'b011 on the next cycle -> one cycle later tm = 8'h AB ({10,101,011}) with tm_valid = 1 for 1 cycle.
REQ-031 Timeout: FLUSH_CYCLES = 4, accept q = 3'b110, then idle -> tm = 8'h 70 ({01,110,000}) with tm_valid rising on cycle 5 after the accept.
REQ-032 Flush: accept q = 3'b001, assert flush on the next cycle -> tm = 8'h 48 on the following cycle; flush asserted in EMPTY -> no output.
REQ-033 Backpressure: tm_ready = 0 with a word pending and HALF held -> q_ready = 0 and tm stable; raise tm_ready -> the pending word is taken and the next word loads the same cycle.
REQ-034 Tie: the second accept lands on the timeout cycle -> a pair word (count 2'b10) only, and no single word is emitted.
REQ-035 Reset mid-operation: rst = 0 with HALF held and tm_valid = 1 -> tm_valid = 0 and q_ready = 0 immediately; after release, a pair of triples produces a correct 2'b10 word.
